// File: rtl/pio_input_conditioner.sv
// Conditions the raw KEY and SW pins: two-flop synchronizer, stability-counter debouncer
// and registered single-cycle edge pulses for each bit.
module pio_input_conditioner #(
    parameter int NUM_KEYS        = 4,
    parameter int NUM_SW          = 10,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic                clk_clk,
    input  logic                reset_reset_n,
    input  logic [NUM_KEYS-1:0] key_raw_n,
    input  logic [NUM_SW-1:0]   sw_raw,
    output logic [NUM_KEYS-1:0] key_clean,
    output logic [NUM_KEYS-1:0] key_clean_n,
    output logic [NUM_SW-1:0]   sw_clean,
    output logic [NUM_KEYS-1:0] key_press_pulse,
    output logic [NUM_KEYS-1:0] key_rel_pulse,
    output logic [NUM_SW-1:0]   sw_change_pulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [NUM_KEYS-1:0] key_s1, key_s2;
    logic [NUM_SW-1:0]   sw_s1, sw_s2;
    logic [NUM_KEYS-1:0] key_lvl;
    logic [CNT_W-1:0]    key_cnt [NUM_KEYS];
    logic [CNT_W-1:0]    sw_cnt  [NUM_SW];

    // Key synchronizer holds the raw pin level (idle = 1); the debouncer sees pressed = 1.
    always_comb begin
        key_lvl = ~key_s2;
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            key_s1          <= '1;
            key_s2          <= '1;
            sw_s1           <= '0;
            sw_s2           <= '0;
            key_clean       <= '0;
            key_clean_n     <= '1;
            sw_clean        <= '0;
            key_press_pulse <= '0;
            key_rel_pulse   <= '0;
            sw_change_pulse <= '0;
            for (int unsigned i = 0; i < NUM_KEYS; i++) key_cnt[i] <= '0;
            for (int unsigned i = 0; i < NUM_SW; i++)   sw_cnt[i]  <= '0;
        end else begin
            key_s1          <= key_raw_n;
            key_s2          <= key_s1;
            sw_s1           <= sw_raw;
            sw_s2           <= sw_s1;
            key_press_pulse <= '0;
            key_rel_pulse   <= '0;
            sw_change_pulse <= '0;

            for (int unsigned i = 0; i < NUM_KEYS; i++) begin
                if (key_lvl[i] == key_clean[i]) begin
                    key_cnt[i] <= '0;
                end else if (key_cnt[i] == CNT_LAST) begin
                    key_clean[i]       <= key_lvl[i];
                    key_clean_n[i]     <= ~key_lvl[i];
                    key_press_pulse[i] <= key_lvl[i];
                    key_rel_pulse[i]   <= ~key_lvl[i];
                    key_cnt[i]         <= '0;
                end else begin
                    key_cnt[i] <= key_cnt[i] + CNT_ONE;
                end
            end

            for (int unsigned i = 0; i < NUM_SW; i++) begin
                if (sw_s2[i] == sw_clean[i]) begin
                    sw_cnt[i] <= '0;
                end else if (sw_cnt[i] == CNT_LAST) begin
                    sw_clean[i]        <= sw_s2[i];
                    sw_change_pulse[i] <= 1'b1;
                    sw_cnt[i]          <= '0;
                end else begin
                    sw_cnt[i] <= sw_cnt[i] + CNT_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_pio_input_conditioner.sv
// Scoreboard bench for pio_input_conditioner with DEBOUNCE_CYCLES = 8: expected pulse
// events are queued when stimulus is driven and popped when the DUT pulses.
module tb_pio_input_conditioner;

    localparam int DEB = 8;

    logic       clk_clk = 1'b0;
    logic       reset_reset_n = 1'b0;
    logic [3:0] key_raw_n = 4'hF;
    logic [9:0] sw_raw = '0;
    logic [3:0] key_clean, key_clean_n, key_press_pulse, key_rel_pulse;
    logic [9:0] sw_clean, sw_change_pulse;

    typedef struct {
        int          cyc;
        logic [17:0] pulses;   // {press, rel, sw_change}
        logic [17:0] clean;    // {key_clean, key_clean_n, sw_clean}
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    pio_input_conditioner #(
        .NUM_KEYS(4),
        .NUM_SW(10),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk_clk(clk_clk),
        .reset_reset_n(reset_reset_n),
        .key_raw_n(key_raw_n),
        .sw_raw(sw_raw),
        .key_clean(key_clean),
        .key_clean_n(key_clean_n),
        .sw_clean(sw_clean),
        .key_press_pulse(key_press_pulse),
        .key_rel_pulse(key_rel_pulse),
        .sw_change_pulse(sw_change_pulse)
    );

    always #5 clk_clk = ~clk_clk;
    always @(posedge clk_clk) cyc <= cyc + 1;

    // Waits for any pulse; seen = -1 when the budget expires.
    task automatic wait_pulse(input int max_cyc, output int seen);
        seen = -1;
        for (int n = 0; n < max_cyc; n++) begin
            @(negedge clk_clk);
            if ({key_press_pulse, key_rel_pulse, sw_change_pulse} != 18'd0) begin
                seen = cyc;
                break;
            end
        end
    endtask

    // Raw driven after negedge at cycle N lands before edge N+1; clean shows at N+2+DEB.
    function automatic int due(input int n);
        return n + 2 + DEB;
    endfunction

    task automatic test_reset();
        reset_reset_n = 1'b0;
        key_raw_n     = 4'hF;
        sw_raw        = '0;
        repeat (3) @(negedge clk_clk);
        checks++;
        if ({key_clean, key_clean_n, sw_clean} !== {4'h0, 4'hF, 10'h000})
            $display("FAIL reset_clean actual=%h required=%h",
                     {key_clean, key_clean_n, sw_clean}, {4'h0, 4'hF, 10'h000});
        checks++;
        if ({key_press_pulse, key_rel_pulse, sw_change_pulse} !== 18'd0)
            $display("FAIL reset_pulses actual=%h required=0",
                     {key_press_pulse, key_rel_pulse, sw_change_pulse});
        reset_reset_n = 1'b1;
        repeat (4) @(negedge clk_clk);
    endtask

    task automatic test_key_press();
        exp_t e;
        int   seen;
        key_raw_n = 4'hE;
        sb.push_back('{due(cyc), {4'b0001, 4'b0000, 10'h000}, {4'b0001, 4'b1110, 10'h000}});
        wait_pulse(30, seen);
        e = sb.pop_front();
        checks++;
        if (seen !== e.cyc) begin errors++; $display("FAIL press_latency actual=%0d required=%0d", seen, e.cyc); end
        checks++;
        if ({key_press_pulse, key_rel_pulse, sw_change_pulse} !== e.pulses) begin
            errors++; $display("FAIL press_pulses actual=%h required=%h", {key_press_pulse, key_rel_pulse, sw_change_pulse}, e.pulses);
        end
        checks++;
        if ({key_clean, key_clean_n, sw_clean} !== e.clean) begin
            errors++; $display("FAIL press_clean actual=%h required=%h", {key_clean, key_clean_n, sw_clean}, e.clean);
        end
        @(negedge clk_clk);
        checks++;
        if ({key_press_pulse, key_rel_pulse, sw_change_pulse, key_clean} !== {18'd0, 4'b0001}) begin
            errors++; $display("FAIL press_one_cycle actual=%h required=%h", {key_press_pulse, key_rel_pulse, sw_change_pulse, key_clean}, {18'd0, 4'b0001});
        end
    endtask

    task automatic test_glitch();
        exp_t e;
        int   seen;
        int   bad = 0;
        for (int t = 0; t < 20; t++) begin
            key_raw_n[1] = ~key_raw_n[1];
            repeat (3) begin
                @(negedge clk_clk);
                if (key_clean[1] !== 1'b0 || {key_press_pulse, key_rel_pulse, sw_change_pulse} != 18'd0) bad++;
            end
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL glitch_reject actual=%0d required=0", bad); end
        key_raw_n[1] = 1'b0;
        sb.push_back('{due(cyc), {4'b0010, 4'b0000, 10'h000}, {4'b0011, 4'b1100, 10'h000}});
        wait_pulse(30, seen);
        e = sb.pop_front();
        checks++;
        if (seen !== e.cyc) begin errors++; $display("FAIL glitch_latency actual=%0d required=%0d", seen, e.cyc); end
        checks++;
        if ({key_press_pulse, key_rel_pulse, sw_change_pulse} !== e.pulses) begin
            errors++; $display("FAIL glitch_pulses actual=%h required=%h", {key_press_pulse, key_rel_pulse, sw_change_pulse}, e.pulses);
        end
        checks++;
        if ({key_clean, key_clean_n, sw_clean} !== e.clean) begin
            errors++; $display("FAIL glitch_clean actual=%h required=%h", {key_clean, key_clean_n, sw_clean}, e.clean);
        end
    endtask

    task automatic test_sw_change();
        exp_t e;
        int   seen;
        @(negedge clk_clk);
        sw_raw = 10'h2A5;
        sb.push_back('{due(cyc), {4'b0000, 4'b0000, 10'h2A5}, {4'b0011, 4'b1100, 10'h2A5}});
        wait_pulse(30, seen);
        e = sb.pop_front();
        checks++;
        if (seen !== e.cyc) begin errors++; $display("FAIL sw_latency actual=%0d required=%0d", seen, e.cyc); end
        checks++;
        if ({key_press_pulse, key_rel_pulse, sw_change_pulse} !== e.pulses) begin
            errors++; $display("FAIL sw_pulses actual=%h required=%h", {key_press_pulse, key_rel_pulse, sw_change_pulse}, e.pulses);
        end
        checks++;
        if ({key_clean, key_clean_n, sw_clean} !== e.clean) begin
            errors++; $display("FAIL sw_clean actual=%h required=%h", {key_clean, key_clean_n, sw_clean}, e.clean);
        end
        @(negedge clk_clk);
        checks++;
        if ({key_press_pulse, key_rel_pulse, sw_change_pulse} !== 18'd0) begin
            errors++; $display("FAIL sw_one_cycle actual=%h required=0", {key_press_pulse, key_rel_pulse, sw_change_pulse});
        end
    endtask

    task automatic test_reset_midcount();
        exp_t e;
        int   seen;
        key_raw_n[2] = 1'b0;
        repeat (7) @(negedge clk_clk);
        reset_reset_n = 1'b0;
        @(negedge clk_clk);
        checks++;
        if ({key_clean, key_clean_n, sw_clean, key_press_pulse, key_rel_pulse, sw_change_pulse} !== {4'h0, 4'hF, 10'h000, 18'd0}) begin
            errors++; $display("FAIL midcount_reset actual=%h required=%h",
                {key_clean, key_clean_n, sw_clean, key_press_pulse, key_rel_pulse, sw_change_pulse}, {4'h0, 4'hF, 10'h000, 18'd0});
        end
        reset_reset_n = 1'b1;
        // Held keys 0..2 and the held switches all re-report after reset.
        sb.push_back('{due(cyc), {4'b0111, 4'b0000, 10'h2A5}, {4'b0111, 4'b1000, 10'h2A5}});
        wait_pulse(30, seen);
        e = sb.pop_front();
        checks++;
        if (seen !== e.cyc) begin errors++; $display("FAIL midcount_latency actual=%0d required=%0d", seen, e.cyc); end
        checks++;
        if ({key_press_pulse, key_rel_pulse, sw_change_pulse} !== e.pulses) begin
            errors++; $display("FAIL midcount_pulses actual=%h required=%h", {key_press_pulse, key_rel_pulse, sw_change_pulse}, e.pulses);
        end
        checks++;
        if ({key_clean, key_clean_n, sw_clean} !== e.clean) begin
            errors++; $display("FAIL midcount_clean actual=%h required=%h", {key_clean, key_clean_n, sw_clean}, e.clean);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   seen;
        @(negedge clk_clk);
        key_raw_n[3] = 1'b0;
        sb.push_back('{due(cyc), {4'b1000, 4'b0000, 10'h000}, {4'b1111, 4'b0000, 10'h2A5}});
        wait_pulse(30, seen);
        e = sb.pop_front();
        checks++;
        if (seen !== e.cyc || {key_press_pulse, key_rel_pulse, sw_change_pulse} !== e.pulses) begin
            errors++; $display("FAIL key3_press actual=%0d/%h required=%0d/%h", seen,
                {key_press_pulse, key_rel_pulse, sw_change_pulse}, e.cyc, e.pulses);
        end
        @(negedge clk_clk);
        key_raw_n[3] = 1'b1;
        sw_raw[0]    = 1'b0;
        sb.push_back('{due(cyc), {4'b0000, 4'b1000, 10'h001}, {4'b0111, 4'b1000, 10'h2A4}});
        wait_pulse(30, seen);
        e = sb.pop_front();
        checks++;
        if (seen !== e.cyc) begin errors++; $display("FAIL simul_latency actual=%0d required=%0d", seen, e.cyc); end
        checks++;
        if ({key_press_pulse, key_rel_pulse, sw_change_pulse} !== e.pulses) begin
            errors++; $display("FAIL simul_pulses actual=%h required=%h", {key_press_pulse, key_rel_pulse, sw_change_pulse}, e.pulses);
        end
        checks++;
        if ({key_clean, key_clean_n, sw_clean} !== e.clean) begin
            errors++; $display("FAIL simul_clean actual=%h required=%h", {key_clean, key_clean_n, sw_clean}, e.clean);
        end
        repeat (20) @(negedge clk_clk);
        checks++;
        if ({key_press_pulse, key_rel_pulse, sw_change_pulse, key_clean, sw_clean} !== {18'd0, 4'b0111, 10'h2A4}) begin
            errors++; $display("FAIL hold_quiet actual=%h required=%h",
                {key_press_pulse, key_rel_pulse, sw_change_pulse, key_clean, sw_clean}, {18'd0, 4'b0111, 10'h2A4});
        end
    endtask

    initial begin
        test_reset();
        test_key_press();
        test_glitch();
        test_sw_change();
        test_reset_midcount();
        test_back_to_back();
        checks++;
        if (sb.size() !== 0) begin errors++; $display("FAIL scoreboard_left actual=%0d required=0", sb.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
